// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and window-element indexing for the conv front end.
// Rev 1.0
`default_nettype none

package conv_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int DEF_K      = 5;
  localparam int DEF_STRIDE = 1;

  // Flattened position of window element (row i, col j); shared with the PE array.
  function automatic int elem_idx(input int i, input int j, input int k = DEF_K);
    return i * k + j;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_line_ram.sv
// conv_line_ram: K-1 circular line rows, one pixel write port, one column read port.
// Rev 1.0
`default_nettype none

module conv_line_ram
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int K      = DEF_K,
  parameter int PTR_W  = clog2_min1(K - 1),
  parameter int COL_W  = clog2_min1(IMG_W)
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [PTR_W-1:0]           wr_row,
  input  logic [COL_W-1:0]           wr_col,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [COL_W-1:0]           rd_col,
  input  logic [PTR_W-1:0]           rd_base,
  output logic [(K-1)*DATA_W-1:0]    rd_data
);

  logic [DATA_W-1:0] mem [K-1][IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Lane 0 is the oldest row: the one about to be overwritten at rd_base.
  for (genvar gi = 0; gi < K - 1; gi++) begin : g_rd
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    assign sum = {1'b0, rd_base} + (PTR_W+1)'(gi);
    assign idx = PTR_W'((sum >= (PTR_W+1)'(K - 1)) ? sum - (PTR_W+1)'(K - 1) : sum);
    assign rd_data[gi*DATA_W +: DATA_W] = mem[idx][rd_col];
  end

endmodule

`default_nettype wire

// File: rtl/conv_window_gen.sv
// conv_window_gen: K x K sliding-window generator over a raster pixel stream, AXI-Stream in/out.
// Rev 1.0
`default_nettype none

module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DATA_W-1:0]       s_axis_data,
  input  logic                    s_axis_valid,
  output logic                    s_axis_ready,
  output logic [K*K*DATA_W-1:0]   m_axis_data,
  output logic                    m_axis_valid,
  input  logic                    m_axis_ready,
  output logic                    m_axis_last,
  output logic                    frame_done
);

  localparam int COL_W = clog2_min1(IMG_W);
  localparam int ROW_W = clog2_min1(IMG_H);
  localparam int PTR_W = clog2_min1(K - 1);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(K - 2);
  localparam logic [COL_W-1:0] COL_START = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_START = ROW_W'(K - 1);
  localparam logic [COL_W-1:0] COL_FINAL = COL_W'(IMG_W - 1 - ((IMG_W - K) % STRIDE));
  localparam logic [ROW_W-1:0] ROW_FINAL = ROW_W'(IMG_H - 1 - ((IMG_H - K) % STRIDE));

  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic [PTR_W-1:0]          wr_ptr;
  logic                      run;
  logic                      out_valid;
  logic                      out_last;
  logic [K*K*DATA_W-1:0]     out_data;
  logic                      done_q;

  logic                      accept;
  logic                      emit;
  logic                      col_ok;
  logic                      row_ok;
  logic [31:0]               col_off;
  logic [31:0]               row_off;
  logic [(K-1)*DATA_W-1:0]   col_rd;
  logic [K*K*DATA_W-1:0]     win_flat;

  logic [DATA_W-1:0] win      [K][K];
  logic [DATA_W-1:0] next_win [K][K];

  assign s_axis_ready = run & (~out_valid | m_axis_ready);
  assign accept       = s_axis_valid & s_axis_ready;
  assign m_axis_data  = out_data;
  assign m_axis_valid = out_valid;
  assign m_axis_last  = out_last;
  assign frame_done   = done_q;

  // Offsets wrap when below K-1, but the >= test gates those positions out.
  assign col_off = 32'(col) - 32'(K - 1);
  assign row_off = 32'(row) - 32'(K - 1);
  assign col_ok  = (col >= COL_START) && ((col_off % 32'(STRIDE)) == 32'd0);
  assign row_ok  = (row >= ROW_START) && ((row_off % 32'(STRIDE)) == 32'd0);
  assign emit    = col_ok & row_ok;

  conv_line_ram #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .K      (K),
    .PTR_W  (PTR_W),
    .COL_W  (COL_W)
  ) u_line_ram (
    .clk     (i_clk),
    .wr_en   (accept),
    .wr_row  (wr_ptr),
    .wr_col  (col),
    .wr_data (s_axis_data),
    .rd_col  (col),
    .rd_base (wr_ptr),
    .rd_data (col_rd)
  );

  always_comb begin
    next_win = win;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        next_win[i][j] = win[i][j+1];
      end
    end
    for (int i = 0; i < K - 1; i++) begin
      next_win[i][K-1] = col_rd[i*DATA_W +: DATA_W];
    end
    next_win[K-1][K-1] = s_axis_data;
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_flat[elem_idx(i, j, K)*DATA_W +: DATA_W] = next_win[i][j];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      win <= next_win;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      run       <= 1'b0;
      col       <= '0;
      row       <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done_q    <= 1'b0;
    end else begin
      run    <= 1'b1;
      done_q <= accept && (col == COL_LAST) && (row == ROW_LAST);
      if (accept) begin
        if (col == COL_LAST) begin
          col    <= '0;
          row    <= (row == ROW_LAST) ? '0 : row + 1'b1;
          wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // accept implies the output slot is free or being drained this cycle.
      if (accept && emit) begin
        out_data  <= win_flat;
        out_valid <= 1'b1;
        out_last  <= (row == ROW_FINAL) && (col == COL_FINAL);
      end else if (m_axis_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
